bp_update_ctrl: RTL
===================

// Module: bp_update_ctrl
// PURPOSE
//   Sequencer between the MEM stage and the local-history branch predictor (LHT/PHT).
//   Captures each resolved conditional branch once, compares it with the prediction
//   carried in its state word, and raises a one-cycle redirect/flush on a mispredict.
//   Queues predictor training updates in a small FIFO and drains one per cycle when
//   the predictor update port is free. Keeps saturating branch/mispredict counters.
// PARAMETERS
//   DEPTH     4   update FIFO entries; power of two, >= 2
//   CNT_W     32  width of each performance counter
// PORTS
//   clk           in   1    clock
//   rst           in   1    synchronous, active-high reset
//   mem_valid     in   1    MEM stage holds a valid instruction
//   mem_is_br     in   1    MEM instruction is a conditional branch
//   mem_taken     in   1    resolved branch outcome (1 = taken)
//   mem_pc        in   32   PC of the MEM instruction
//   mem_target    in   32   resolved branch target
//   mem_state     in   SW   state_word_t captured at fetch (SW = $bits(state_word_t))
//   pipe_stall    in   1    MEM is held this cycle; no capture
//   upd_ready     in   1    predictor accepts an update this cycle
//   upd_valid     out  1    update presented to the predictor
//   upd_state     out  SW   state word of the head entry
//   upd_taken     out  1    outcome of the head entry
//   redirect      out  1    mispredict; flush IF/ID/EX and refetch
//   redirect_pc   out  32   refetch address
//   stall_req     out  1    FIFO full; front end must hold MEM
//   q_count       out  $clog2(DEPTH)+1  FIFO occupancy
//   overflow_err  out  1    sticky: a capture was dropped
//   perf_branches out  CNT_W  captured branches, saturating
//   perf_mispred  out  CNT_W  mispredicted branches, saturating
// BEHAVIOUR
//   capture = mem_valid & mem_is_br & ~pipe_stall. A stalled branch is captured
//     exactly once, on its last (unstalled) MEM cycle.
//   pred_taken = (mem_state.state == wt) | (mem_state.state == st).
//   mispred = capture & (pred_taken != mem_taken).
//   redirect = mispred, combinational, same cycle as capture.
//   redirect_pc = mem_taken ? mem_target : mem_pc + 32'd4 (mod 2^32).
//   redirect_pc = 32'b0 whenever redirect = 0.
//   Enqueue: on capture, push {mem_state, mem_taken}. An entry is visible at the
//     head no earlier than the cycle after capture; there is no bypass.
//   Dequeue: upd_valid = (count != 0); the head pops when upd_valid & upd_ready.
//   Full with simultaneous pop: the push is accepted; count is unchanged.
//   Full without a pop: the capture is dropped, overflow_err is set (sticky until
//     rst), and both perf counters still count it.
//   stall_req = (count == DEPTH), registered occupancy only.
//   Empty: upd_valid = 0; upd_state and upd_taken hold the last head value
//     (0 after reset).
//   Pointers wrap modulo DEPTH; count saturates at neither end (guarded as above).
//   perf_branches += capture; perf_mispred += mispred; each holds at all-ones.
//   Reset: FIFO emptied, count = 0, all counters 0, overflow_err = 0.
//     Outputs during and after reset: upd_valid = 0, stall_req = 0, redirect = 0.
//     Combinational outputs are masked while rst is high.
//   Reset mid-operation discards queued updates; the predictor is reset by the same rst.
// STRUCTURE
//   Package types: reuse state_t and state_word_t.
//     Add bp_upd_t = packed struct {state_word_t sw; logic taken;}.
//   Sub-module bp_fifo #(type T, DEPTH): sync FIFO; push/pop/full/empty/count,
//     no bypass, push-when-full ignored. The controller owns capture, redirect,
//     counters and the overflow flag.
// TESTING
//   1. Reset, then branch state=wn, taken=1, pc=0x100, target=0x80:
//      redirect=1, redirect_pc=0x80 same cycle; next cycle upd_valid=1,
//      upd_taken=1; perf_mispred=1.
//   2. state=st, taken=1, pc=0x200: redirect=0; perf_branches=1, perf_mispred=0;
//      the update drains the cycle after capture with upd_ready=1.
//   3. Branch held with pipe_stall=1 for 3 cycles, then released:
//      exactly one capture, q_count peaks at 1, perf_branches=1.
//   4. upd_ready=0, 4 back-to-back branches: q_count=4 and stall_req=1.
//      A 5th capture sets overflow_err=1 and leaves q_count=4. Then raise
//      upd_ready: the 4 entries drain in FIFO order, one per cycle.
//   5. Full FIFO, capture and pop in the same cycle: q_count stays 4 and the
//      new entry sits at the tail.
//   6. rst asserted with 3 entries queued: next cycle q_count=0, upd_valid=0,
//      counters=0, overflow_err=0.

Source files
------------

// File: rtl/bp_update_ctrl_pkg.sv
// bp_update_ctrl_pkg: predictor state encodings and the update-queue entry type
package bp_update_ctrl_pkg;
  typedef enum logic [1:0] {sn, wn, wt, st} state_t;
  typedef struct packed {
    logic [9:0] lht_idx;
    logic [3:0] hist;
    state_t     state;
  } state_word_t;
  typedef struct packed {
    state_word_t sw;
    logic        taken;
  } bp_upd_t;
  function automatic logic pred_taken(state_t s);
    return (s == wt) || (s == st);
  endfunction
endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if: MEM-stage capture inputs and predictor update / redirect outputs
interface bp_update_ctrl_if #(parameter int DEPTH = 4, parameter int CNT_W = 32);
  import bp_update_ctrl_pkg::*;
  logic                     mem_valid;
  logic                     mem_is_br;
  logic                     mem_taken;
  logic [31:0]              mem_pc;
  logic [31:0]              mem_target;
  state_word_t              mem_state;
  logic                     pipe_stall;
  logic                     upd_ready;
  logic                     upd_valid;
  state_word_t              upd_state;
  logic                     upd_taken;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     stall_req;
  logic [$clog2(DEPTH):0]   q_count;
  logic                     overflow_err;
  logic [CNT_W-1:0]         perf_branches;
  logic [CNT_W-1:0]         perf_mispred;
  modport master (
    output mem_valid, mem_is_br, mem_taken, mem_pc, mem_target, mem_state, pipe_stall, upd_ready,
    input  upd_valid, upd_state, upd_taken, redirect, redirect_pc, stall_req, q_count,
           overflow_err, perf_branches, perf_mispred
  );
  modport slave (
    input  mem_valid, mem_is_br, mem_taken, mem_pc, mem_target, mem_state, pipe_stall, upd_ready,
    output upd_valid, upd_state, upd_taken, redirect, redirect_pc, stall_req, q_count,
           overflow_err, perf_branches, perf_mispred
  );
endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// bp_fifo: synchronous FIFO, no bypass, push-when-full ignored unless a pop frees the slot
module bp_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  T last;
  logic [AW-1:0] wr, rd;
  logic push_ok, pop_ok;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // when empty the output holds whatever was last popped
  assign dout    = empty ? last : mem[rd];
  always_ff @(posedge clk)
    if (push_ok) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop_ok) begin
        last <= mem[rd];
        rd   <= rd + 1'b1;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: captures resolved branches, flags mispredicts and queues predictor training
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  bp_update_ctrl_if.slave bus
);
  logic    capture, mispred, pop, full, empty;
  bp_upd_t head;
  assign capture = ~rst & bus.mem_valid & bus.mem_is_br & ~bus.pipe_stall;
  assign mispred = capture & (pred_taken(bus.mem_state.state) != bus.mem_taken);
  assign pop     = ~rst & ~empty & bus.upd_ready;
  bp_fifo #(.T(bp_upd_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   ('{sw: bus.mem_state, taken: bus.mem_taken}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (bus.q_count)
  );
  assign bus.redirect    = mispred;
  assign bus.redirect_pc = ~mispred ? 32'b0 : bus.mem_taken ? bus.mem_target : bus.mem_pc + 32'd4;
  assign bus.upd_valid   = ~rst & ~empty;
  assign bus.stall_req   = ~rst & full;
  assign bus.upd_state   = head.sw;
  assign bus.upd_taken   = head.taken;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.overflow_err  <= 1'b0;
      bus.perf_branches <= '0;
      bus.perf_mispred  <= '0;
    end else begin
      bus.overflow_err  <= bus.overflow_err | (capture & full & ~pop);
      bus.perf_branches <= bus.perf_branches + CNT_W'(capture & ~&bus.perf_branches);
      bus.perf_mispred  <= bus.perf_mispred + CNT_W'(mispred & ~&bus.perf_mispred);
    end
  end
endmodule
